seg_scan_ctrl: RTL

- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display on the board.
- Owns the shared segment bus and decides which digit drives it in each scan slot.
- Upstream producers (ping-pong counter, direction indicator) hand it complete frames through a valid/ready port.
- Frames are double-buffered so the display only changes at a frame boundary and never shows a torn frame.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_hex_decode.sv | 20 ++
 rtl/seg_scan_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and frame layout for the seven-segment scan controller.
package seg_pkg;

  localparam int unsigned FRAME_W    = 24;
  localparam int unsigned DIGITS_LSB = 0;
  localparam int unsigned BLANK_LSB  = 16;
  localparam int unsigned DP_LSB     = 20;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low segment patterns {a,b,c,d,e,f,g,dp}; dp bit left dark.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h71, 8'h61, 8'h85, 8'h63,  // F E d C
    8'hC1, 8'h11, 8'h09, 8'h01,  // b A 9 8
    8'h1F, 8'h41, 8'h49, 8'h99,  // 7 6 5 4
    8'h0D, 8'h25, 8'h9F, 8'h03   // 3 2 1 0
  };

  // One display frame; field order matches the offsets above.
  typedef struct packed {
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [15:0] digits;
  } frame_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low seven-segment pattern with blanking and decimal point.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg_c
);

  // Blanking overrides both the glyph and the decimal point.
  always_comb begin
    seg_c    = SEG_LUT[nibble];
    seg_c[0] = ~dp;
    if (blank) begin
      seg_c = SEG_OFF;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller with a double-buffered frame port.
// Optional build macro: LEADING_ZERO_BLANK_EN (auto-blank leading zero digits 3..1).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_digits,
  input  logic [3:0]  upd_blank,
  input  logic [3:0]  upd_dp,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  frame_t           disp;
  frame_t           pend;
  logic             tick_c;
  logic             boundary_c;
  logic [3:0]       nib_c;
  logic [3:0]       lz_c;
  logic             blank_c;
  logic             dp_c;
  logic [7:0]       dec_c;

  assign tick_c     = en && (cnt == CNT_LAST);
  assign boundary_c = tick_c && (idx == 2'd3);

  // Prescaler and digit index; both freeze while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (tick_c) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Pending slot: promote at a frame boundary, otherwise accept an offered frame.
  // upd_ready doubles as the "pending empty" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp      <= '0;
      pend      <= '0;
      upd_ready <= 1'b1;
    end else if (boundary_c && !upd_ready) begin
      disp      <= pend;
      upd_ready <= 1'b1;
    end else if (upd_valid && upd_ready) begin
      pend      <= '{dp: upd_dp, blank: upd_blank, digits: upd_digits};
      upd_ready <= 1'b0;
    end
  end

  // Leading-zero mask: a digit is dark when it and every higher nibble are zero.
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_c    = '0;
    lz_c[3] = (disp.digits[15:12] == 4'h0);
    lz_c[2] = lz_c[3] && (disp.digits[11:8] == 4'h0);
    lz_c[1] = lz_c[2] && (disp.digits[7:4] == 4'h0);
  end
`else
  always_comb begin
    lz_c = '0;
  end
`endif

  // Select the nibble and attributes of the digit currently being scanned.
  always_comb begin
    nib_c = disp.digits[3:0];
    case (idx)
      2'd0:    nib_c = disp.digits[3:0];
      2'd1:    nib_c = disp.digits[7:4];
      2'd2:    nib_c = disp.digits[11:8];
      default: nib_c = disp.digits[15:12];
    endcase
    blank_c = disp.blank[idx] | lz_c[idx];
    dp_c    = disp.dp[idx];
  end

  seg_hex_decode u_dec (
    .nibble (nib_c),
    .blank  (blank_c),
    .dp     (dp_c),
    .seg_c  (dec_c)
  );

  // Registered display drive and frame boundary pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary_c;
      if (en) begin
        an  <= ~(4'b0001 << idx);
        seg <= dec_c;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end
    end
  end

endmodule
